// File: rtl/cursor_pkg.sv
// Shared types and helpers for the cursor glide scheduler.
package cursor_pkg;

   typedef enum logic [1:0] {StIdle, StGlide, StSettle, StDone} state_e;

   localparam int unsigned BOARD_X0 = 96;
   localparam int unsigned BOARD_Y0 = 16;

   // Signed per-frame step toward tgt on one axis.
   function automatic logic signed [7:0] step_byte(input logic [2:0] cur,
                                                   input logic [2:0] tgt,
                                                   input int unsigned step);
      logic [7:0] mag;
      mag = 8'(step);
      if (cur < tgt) return $signed(mag);
      else if (cur > tgt) return $signed(8'h00 - mag);
      return '0;
   endfunction

endpackage

// File: rtl/cursor_glide_sched_if.sv
// Request/response bundle between move requesters and the glide scheduler.
interface cursor_glide_sched_if;
   logic        kb_valid;
   logic [2:0]  kb_col;
   logic [2:0]  kb_row;
   logic        kb_ready;
   logic        ai_valid;
   logic [2:0]  ai_col;
   logic [2:0]  ai_row;
   logic        ai_ready;
   logic [15:0] keycode;
   logic        busy;
   logic        done;
   logic        grant_src;
   logic [2:0]  cur_col;
   logic [2:0]  cur_row;

   modport master (
      output kb_valid, kb_col, kb_row, ai_valid, ai_col, ai_row,
      input  kb_ready, ai_ready, keycode, busy, done, grant_src, cur_col, cur_row
   );

   modport slave (
      input  kb_valid, kb_col, kb_row, ai_valid, ai_col, ai_row,
      output kb_ready, ai_ready, keycode, busy, done, grant_src, cur_col, cur_row
   );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; index 0 = keyboard, 1 = AI.
module rr_arb2 (
   input  logic       i_en,
   input  logic [1:0] i_valid,
   input  logic       i_last_grant,
   output logic [1:0] o_ready,
   output logic       o_grant
);

   logic w_grant;

   // On a tie the source opposite the previous winner goes first.
   assign w_grant = (&i_valid) ? ~i_last_grant : i_valid[1];

   assign o_grant    = w_grant;
   assign o_ready[0] = i_en & i_valid[0] & ~w_grant;
   assign o_ready[1] = i_en & i_valid[1] &  w_grant;

endmodule

// File: rtl/cursor_glide_sched.sv
// Arbitrates square moves and glides the cursor there one square per FPS frames.
module cursor_glide_sched
   import cursor_pkg::*;
#(
   parameter int unsigned SQ_SIZE       = 56,
   parameter int unsigned STEP          = 4,
   parameter int unsigned SETTLE_FRAMES = 2,
   parameter int unsigned HOME_COL      = 4,
   parameter int unsigned HOME_ROW      = 4
) (
   input logic           frame_clk,
   input logic           Reset,
   cursor_glide_sched_if.slave bus
);

   localparam int unsigned FPS     = SQ_SIZE / STEP;
   localparam int unsigned CNT_MAX = ((FPS > SETTLE_FRAMES) ? FPS : SETTLE_FRAMES) - 1;
   localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] FPS_LAST    = CNT_W'(FPS - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_FRAMES - 1);

   state_e           r_state, w_state_nxt;
   logic [2:0]       r_cur_col, w_cur_col_nxt;
   logic [2:0]       r_cur_row, w_cur_row_nxt;
   logic [2:0]       r_tgt_col, w_tgt_col_nxt;
   logic [2:0]       r_tgt_row, w_tgt_row_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_last_grant, w_last_grant_nxt;
   logic             r_grant_src, w_grant_src_nxt;

   logic [1:0] w_ready;
   logic       w_grant;
   logic [2:0] w_req_col, w_req_row;
   logic [2:0] w_col_step, w_row_step;

   rr_arb2 u_arb (
      .i_en         (r_state == StIdle),
      .i_valid      ({bus.ai_valid, bus.kb_valid}),
      .i_last_grant (r_last_grant),
      .o_ready      (w_ready),
      .o_grant      (w_grant)
   );

   assign w_req_col = w_grant ? bus.ai_col : bus.kb_col;
   assign w_req_row = w_grant ? bus.ai_row : bus.kb_row;

   assign w_col_step = (r_cur_col < r_tgt_col) ? r_cur_col + 3'd1 :
                       (r_cur_col > r_tgt_col) ? r_cur_col - 3'd1 : r_cur_col;
   assign w_row_step = (r_cur_row < r_tgt_row) ? r_cur_row + 3'd1 :
                       (r_cur_row > r_tgt_row) ? r_cur_row - 3'd1 : r_cur_row;

   always_comb begin
      w_state_nxt      = r_state;
      w_cur_col_nxt    = r_cur_col;
      w_cur_row_nxt    = r_cur_row;
      w_tgt_col_nxt    = r_tgt_col;
      w_tgt_row_nxt    = r_tgt_row;
      w_cnt_nxt        = r_cnt;
      w_last_grant_nxt = r_last_grant;
      w_grant_src_nxt  = r_grant_src;
      unique case (r_state)
         StIdle: begin
            if (|w_ready) begin
               w_tgt_col_nxt    = w_req_col;
               w_tgt_row_nxt    = w_req_row;
               w_grant_src_nxt  = w_grant;
               w_last_grant_nxt = w_grant;
               w_cnt_nxt        = '0;
               w_state_nxt = ((w_req_col != r_cur_col) || (w_req_row != r_cur_row)) ?
                             StGlide : StDone;
            end
         end
         StGlide: begin
            if (r_cnt == FPS_LAST) begin
               w_cnt_nxt     = '0;
               w_cur_col_nxt = w_col_step;
               w_cur_row_nxt = w_row_step;
               if ((w_col_step == r_tgt_col) && (w_row_step == r_tgt_row)) begin
                  w_state_nxt = StSettle;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         StSettle: begin
            if (r_cnt == SETTLE_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = StDone;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         StDone:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         r_state      <= StIdle;
         r_cur_col    <= 3'(HOME_COL);
         r_cur_row    <= 3'(HOME_ROW);
         r_tgt_col    <= 3'(HOME_COL);
         r_tgt_row    <= 3'(HOME_ROW);
         r_cnt        <= '0;
         r_last_grant <= 1'b1;
         r_grant_src  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cur_col    <= w_cur_col_nxt;
         r_cur_row    <= w_cur_row_nxt;
         r_tgt_col    <= w_tgt_col_nxt;
         r_tgt_row    <= w_tgt_row_nxt;
         r_cnt        <= w_cnt_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_grant_src  <= w_grant_src_nxt;
      end
   end

   assign bus.keycode   = (r_state == StGlide) ?
                          {step_byte(r_cur_row, r_tgt_row, STEP),
                           step_byte(r_cur_col, r_tgt_col, STEP)} : 16'h0000;
   assign bus.busy      = (r_state != StIdle);
   assign bus.done      = (r_state == StDone);
   assign bus.kb_ready  = w_ready[0];
   assign bus.ai_ready  = w_ready[1];
   assign bus.grant_src = r_grant_src;
   assign bus.cur_col   = r_cur_col;
   assign bus.cur_row   = r_cur_row;

endmodule

// File: tb/tb_cursor_glide_sched.sv
// Directed and randomized moves checked against a frame-by-frame glide model.
module tb_cursor_glide_sched;
   import cursor_pkg::*;

   localparam int SQ  = 56;
   localparam int STP = 4;
   localparam int SET = 2;
   localparam int FPS = SQ / STP;

   logic frame_clk = 1'b0;
   logic Reset;
   always #5 frame_clk = ~frame_clk;

   cursor_glide_sched_if bus ();

   cursor_glide_sched #(
      .SQ_SIZE       (SQ),
      .STEP          (STP),
      .SETTLE_FRAMES (SET),
      .HOME_COL      (4),
      .HOME_ROW      (4)
   ) dut (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .bus       (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int m_col  = 4;
   int m_row  = 4;
   int m_last = 1;
   int px     = 320;
   int py     = 240;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sgn(input int a, input int b);
      return (b > a) ? 1 : ((b < a) ? -1 : 0);
   endfunction

   function automatic int iabs(input int a);
      return (a < 0) ? -a : a;
   endfunction

   task automatic set_req(input bit src, input bit v, input int col, input int row);
      if (!src) begin
         bus.kb_valid = v; bus.kb_col = 3'(col); bus.kb_row = 3'(row);
      end else begin
         bus.ai_valid = v; bus.ai_col = 3'(col); bus.ai_row = 3'(row);
      end
   endtask

   // Starts at an IDLE negedge, ends at the first IDLE negedge after done.
   task automatic run_move(input bit src, input int col, input int row,
                           input int raise_at, input int o_col, input int o_row);
      int sx, sy, adx, ady, n, k, cx, cy;
      logic [7:0] xb, yb;
      set_req(src, 1'b1, col, row);
      #1;
      chk("ready_src", {15'd0, src ? bus.ai_ready : bus.kb_ready}, 16'd1);
      chk("ready_other", {15'd0, src ? bus.kb_ready : bus.ai_ready}, 16'd0);
      sx = sgn(m_col, col); sy = sgn(m_row, row);
      adx = iabs(col - m_col); ady = iabs(row - m_row);
      n = (adx > ady) ? adx : ady;
      @(negedge frame_clk);
      set_req(src, 1'b0, col, row);
      m_last = src;
      if (n == 0) begin
         chk("zero_flags", {11'd0, bus.busy, bus.done, bus.kb_ready, bus.ai_ready, src},
             {11'd0, 1'b1, 1'b1, 1'b0, 1'b0, src});
         chk("zero_keycode", bus.keycode, 16'h0000);
      end else begin
         for (int f = 0; f < n * FPS; f++) begin
            if (f == raise_at) set_req(!src, 1'b1, o_col, o_row);
            k  = f / FPS;
            cx = m_col + sx * ((k < adx) ? k : adx);
            cy = m_row + sy * ((k < ady) ? k : ady);
            xb = (cx != col) ? 8'(sx * STP) : 8'h00;
            yb = (cy != row) ? 8'(sy * STP) : 8'h00;
            chk("glide_keycode", bus.keycode, {yb, xb});
            chk("glide_cur", {10'd0, bus.cur_row, bus.cur_col}, {10'd0, 3'(cy), 3'(cx)});
            chk("glide_flags", {11'd0, bus.busy, bus.done, bus.kb_ready, bus.ai_ready,
                bus.grant_src}, {11'd0, 1'b1, 1'b0, 1'b0, 1'b0, src});
            px += int'($signed(bus.keycode[7:0]));
            py += int'($signed(bus.keycode[15:8]));
            @(negedge frame_clk);
         end
         for (int s = 0; s < SET; s++) begin
            chk("settle_keycode", bus.keycode, 16'h0000);
            chk("settle_state", {9'd0, bus.busy, bus.done, bus.cur_row, bus.cur_col},
                {9'd0, 1'b1, 1'b0, 3'(row), 3'(col)});
            @(negedge frame_clk);
         end
         chk("done_flags", {11'd0, bus.busy, bus.done, bus.kb_ready, bus.ai_ready,
             bus.grant_src}, {11'd0, 1'b1, 1'b1, 1'b0, 1'b0, src});
         chk("pixel_x", 16'(px), 16'(int'(BOARD_X0) + col * SQ));
         chk("pixel_y", 16'(py), 16'(int'(BOARD_Y0) + row * SQ));
      end
      @(negedge frame_clk);
      m_col = col; m_row = row;
      chk("idle_state", {8'd0, bus.busy, bus.done, bus.grant_src, bus.cur_row, bus.cur_col},
          {8'd0, 1'b0, 1'b0, src, 3'(row), 3'(col)});
   endtask

   // Both sources request together; the model's last winner decides the order.
   task automatic both(input int kc, input int kr, input int ac, input int ar);
      bit w;
      w = (m_last == 1) ? 1'b0 : 1'b1;
      set_req(!w, 1'b1, w ? kc : ac, w ? kr : ar);
      run_move(w, w ? ac : kc, w ? ar : kr, -1, 0, 0);
      run_move(!w, w ? kc : ac, w ? kr : ar, -1, 0, 0);
   endtask

   initial begin
      int tc, tr, ec, er;
      bit s;
      Reset = 1'b1;
      set_req(1'b0, 1'b0, 0, 0);
      set_req(1'b1, 1'b0, 0, 0);
      repeat (2) @(negedge frame_clk);
      chk("reset_keycode", bus.keycode, 16'h0000);
      chk("reset_flags", {11'd0, bus.busy, bus.done, bus.kb_ready, bus.ai_ready,
          bus.grant_src}, 16'd0);
      chk("reset_cur", {10'd0, bus.cur_row, bus.cur_col}, {10'd0, 3'd4, 3'd4});
      Reset = 1'b0;
      @(negedge frame_clk);

      run_move(1'b0, 5, 4, -1, 0, 0);
      run_move(1'b0, 4, 4, -1, 0, 0);
      run_move(1'b0, 2, 1, -1, 0, 0);
      run_move(1'b1, 4, 4, -1, 0, 0);
      run_move(1'b0, 4, 4, -1, 0, 0);
      run_move(1'b0, 6, 5, 5, 1, 6);
      run_move(1'b1, 1, 6, -1, 0, 0);

      for (int i = 0; i < 6; i++) begin
         s  = 1'($urandom_range(0, 1));
         tc = $urandom_range(0, 7);
         tr = $urandom_range(0, 7);
         if ($urandom_range(0, 3) == 0) begin tc = m_col; tr = m_row; end
         run_move(s, tc, tr, -1, 0, 0);
      end

      tc = (m_col == 0 && m_row == 0) ? 7 : 0;
      tr = tc;
      set_req(1'b0, 1'b1, tc, tr);
      ec = sgn(m_col, tc); er = sgn(m_row, tr);
      @(negedge frame_clk);
      set_req(1'b0, 1'b0, tc, tr);
      repeat (7) @(negedge frame_clk);
      chk("frame7_keycode", bus.keycode, {8'(er * STP), 8'(ec * STP)});
      #2 Reset = 1'b1;
      #1;
      chk("midreset_keycode", bus.keycode, 16'h0000);
      chk("midreset_state", {9'd0, bus.busy, bus.done, bus.cur_row, bus.cur_col},
          {9'd0, 1'b0, 1'b0, 3'd4, 3'd4});
      @(negedge frame_clk);
      Reset = 1'b0;
      m_col = 4; m_row = 4; m_last = 1; px = 320; py = 240;
      @(negedge frame_clk);

      both(6, 2, 3, 3);
      both(0, 7, 5, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
